// File: rtl/debug_unit_pkg.sv
// Shared constants for the pipeline debug controller: command bytes, FSM state codes, field widths.
package debug_unit_pkg;

  localparam int unsigned NB_BYTE     = 8;
  localparam int unsigned NB_STATE    = 4;
  localparam int unsigned NB_WORD_CNT = 9;

  localparam logic [NB_BYTE-1:0] CMD_LOAD  = 8'h4C;
  localparam logic [NB_BYTE-1:0] CMD_CONT  = 8'h43;
  localparam logic [NB_BYTE-1:0] CMD_STEP  = 8'h53;
  localparam logic [NB_BYTE-1:0] CMD_BREAK = 8'h42;
  localparam logic [NB_BYTE-1:0] ACK_BYTE  = 8'h4B;

  localparam logic [NB_STATE-1:0] ST_IDLE       = 4'd0;
  localparam logic [NB_STATE-1:0] ST_LOAD_CNT   = 4'd1;
  localparam logic [NB_STATE-1:0] ST_LOAD_BYTE  = 4'd2;
  localparam logic [NB_STATE-1:0] ST_LOAD_WRITE = 4'd3;
  localparam logic [NB_STATE-1:0] ST_RUN        = 4'd4;
  localparam logic [NB_STATE-1:0] ST_STEP       = 4'd5;
  localparam logic [NB_STATE-1:0] ST_DUMP_ADDR  = 4'd6;
  localparam logic [NB_STATE-1:0] ST_DUMP_WAIT  = 4'd7;
  localparam logic [NB_STATE-1:0] ST_DUMP_SEND  = 4'd8;
  localparam logic [NB_STATE-1:0] ST_ACK        = 4'd9;

endpackage

// File: rtl/debug_word_tx.sv
// Serialises one data word into bytes, MSB first, over a valid/ready byte channel.
module debug_word_tx
  import debug_unit_pkg::*;
#(
  parameter int unsigned NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
  localparam int unsigned NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  // Advance only on a completed transfer; a new word is accepted only when idle.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (valid_q && i_tx_ready) begin
      if (cnt_q == NB_CNT'(0)) begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        shift_d = {shift_q[NB_DATA-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
        cnt_d   = cnt_q - NB_CNT'(1);
      end
    end else if (!valid_q && i_load) begin
      shift_d = i_word;
      cnt_d   = NB_CNT'(N_BYTES - 1);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign o_tx_data  = shift_q[NB_DATA-1 -: NB_BYTE];
  assign o_tx_valid = valid_q;
  assign o_busy     = valid_q;
  assign o_done     = done_q;

endmodule

// File: rtl/debug_unit.sv
// Host-side debug controller: loads program memory from a UART byte stream, runs or steps the
// pipeline through its clock enable, then dumps PC, register file and data memory as bytes.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int unsigned NB_DATA           = 32,
  parameter int unsigned NB_ADDRESS        = 32,
  parameter int unsigned N_REGISTERS       = 32,
  parameter int unsigned N_DMEM_WORDS      = 32,
  parameter int unsigned ADDR_INC          = 4,
  parameter int unsigned RD_LATENCY        = 1,
  parameter int unsigned NB_ADDR_REGISTERS = $clog2(N_REGISTERS)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NB_BYTE-1:0]           i_rx_data,
  input  logic                         i_rx_valid,
  output logic [NB_BYTE-1:0]           o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  input  logic [NB_ADDRESS-1:0]        i_if_pc,
  input  logic                         i_if_halt,
  input  logic [NB_DATA-1:0]           i_reg_data,
  input  logic [NB_DATA-1:0]           i_d_mem_data,
  output logic                         o_debug,
  output logic                         o_clk_en,
  output logic                         o_p_mem_w_en,
  output logic [NB_ADDRESS-1:0]        o_p_mem_w_addr,
  output logic [NB_DATA-1:0]           o_p_mem_w_data,
  output logic [NB_ADDRESS-1:0]        o_d_mem_addr,
  output logic [NB_ADDR_REGISTERS-1:0] o_reg_addr
);

  localparam int unsigned N_BYTES   = NB_DATA / NB_BYTE;
  localparam int unsigned NB_BIDX   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int unsigned LAST_ITEM = N_REGISTERS + N_DMEM_WORDS;
  localparam int unsigned NB_ITEM   = $clog2(LAST_ITEM + 1);
  localparam int unsigned NB_WAIT   = 2;

  logic [NB_STATE-1:0]          state_q, state_d;
  logic [NB_WORD_CNT-1:0]       word_cnt_q, word_cnt_d;
  logic [NB_BIDX-1:0]           byte_idx_q, byte_idx_d;
  logic [NB_DATA-NB_BYTE-1:0]   asm_q, asm_d;
  logic [NB_ADDRESS-1:0]        load_addr_q, load_addr_d;
  logic                         w_en_q, w_en_d;
  logic [NB_ADDRESS-1:0]        w_addr_q, w_addr_d;
  logic [NB_DATA-1:0]           w_data_q, w_data_d;
  logic [NB_ITEM-1:0]           item_q, item_d;
  logic [NB_WAIT-1:0]           wait_q, wait_d;
  logic [NB_ADDR_REGISTERS-1:0] reg_addr_q, reg_addr_d;
  logic [NB_ADDRESS-1:0]        dmem_addr_q, dmem_addr_d;

  logic                         wtx_load_c;
  logic [NB_DATA-1:0]           wtx_word_c;
  logic [NB_BYTE-1:0]           wtx_data;
  logic                         wtx_valid;
  logic                         wtx_busy;
  logic                         wtx_done;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    load_addr_d = load_addr_q;
    w_en_d      = 1'b0;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    item_d      = item_q;
    wait_d      = wait_q;
    reg_addr_d  = reg_addr_q;
    dmem_addr_d = dmem_addr_q;
    wtx_load_c  = 1'b0;
    wtx_word_c  = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d     = ST_LOAD_CNT;
              load_addr_d = '0;
            end
            CMD_CONT: state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_CNT: begin
        if (i_rx_valid) begin
          word_cnt_d = (i_rx_data == '0) ? NB_WORD_CNT'(256) : NB_WORD_CNT'(i_rx_data);
          byte_idx_d = '0;
          state_d    = ST_LOAD_BYTE;
        end
      end
      ST_LOAD_BYTE: begin
        if (i_rx_valid) begin
          asm_d = {asm_q[NB_DATA-2*NB_BYTE-1:0], i_rx_data};
          if (byte_idx_q == NB_BIDX'(N_BYTES - 1)) begin
            w_en_d     = 1'b1;
            w_addr_d   = load_addr_q;
            w_data_d   = {asm_q, i_rx_data};
            byte_idx_d = '0;
            state_d    = ST_LOAD_WRITE;
          end else begin
            byte_idx_d = byte_idx_q + NB_BIDX'(1);
          end
        end
      end
      // Strobe cycle; a byte landing here already belongs to the next word.
      ST_LOAD_WRITE: begin
        load_addr_d = load_addr_q + NB_ADDRESS'(ADDR_INC);
        word_cnt_d  = word_cnt_q - NB_WORD_CNT'(1);
        if (word_cnt_q == NB_WORD_CNT'(1)) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_LOAD_BYTE;
          if (i_rx_valid) begin
            asm_d      = {asm_q[NB_DATA-2*NB_BYTE-1:0], i_rx_data};
            byte_idx_d = NB_BIDX'(1);
          end
        end
      end
      ST_ACK: begin
        if (i_tx_ready) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (i_if_halt || (i_rx_valid && (i_rx_data == CMD_BREAK))) begin
          item_d  = '0;
          state_d = ST_DUMP_ADDR;
        end
      end
      ST_STEP: begin
        item_d  = '0;
        state_d = ST_DUMP_ADDR;
      end
      // Item 0 is the PC, then registers, then data-memory words.
      ST_DUMP_ADDR: begin
        if (item_q == NB_ITEM'(1)) begin
          reg_addr_d = '0;
        end else if ((item_q > NB_ITEM'(1)) && (item_q <= NB_ITEM'(N_REGISTERS))) begin
          reg_addr_d = reg_addr_q + NB_ADDR_REGISTERS'(1);
        end
        if (item_q == NB_ITEM'(N_REGISTERS + 1)) begin
          dmem_addr_d = '0;
        end else if (item_q > NB_ITEM'(N_REGISTERS + 1)) begin
          dmem_addr_d = dmem_addr_q + NB_ADDRESS'(ADDR_INC);
        end
        wait_d  = '0;
        state_d = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if ((wait_q == NB_WAIT'(RD_LATENCY)) && !wtx_busy) begin
          wtx_load_c = 1'b1;
          if (item_q == '0) begin
            wtx_word_c = NB_DATA'(i_if_pc);
          end else if (item_q <= NB_ITEM'(N_REGISTERS)) begin
            wtx_word_c = i_reg_data;
          end else begin
            wtx_word_c = i_d_mem_data;
          end
          state_d = ST_DUMP_SEND;
        end else if (wait_q != NB_WAIT'(RD_LATENCY)) begin
          wait_d = wait_q + NB_WAIT'(1);
        end
      end
      ST_DUMP_SEND: begin
        if (wtx_done) begin
          if (item_q == NB_ITEM'(LAST_ITEM)) begin
            state_d = ST_IDLE;
          end else begin
            item_d  = item_q + NB_ITEM'(1);
            state_d = ST_DUMP_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      load_addr_q <= '0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      item_q      <= '0;
      wait_q      <= '0;
      reg_addr_q  <= '0;
      dmem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      load_addr_q <= load_addr_d;
      w_en_q      <= w_en_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      item_q      <= item_d;
      wait_q      <= wait_d;
      reg_addr_q  <= reg_addr_d;
      dmem_addr_q <= dmem_addr_d;
    end
  end

  debug_word_tx #(
    .NB_DATA (NB_DATA)
  ) u_word_tx (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (wtx_load_c),
    .i_word     (wtx_word_c),
    .o_tx_data  (wtx_data),
    .o_tx_valid (wtx_valid),
    .i_tx_ready (i_tx_ready),
    .o_busy     (wtx_busy),
    .o_done     (wtx_done)
  );

  // Clock enable must react to HALT in the same cycle, so it is decoded, not registered.
  assign o_clk_en       = ((state_q == ST_RUN) && !i_if_halt) || (state_q == ST_STEP);
  assign o_debug        = !((state_q == ST_RUN) || (state_q == ST_STEP));
  assign o_tx_valid     = (state_q == ST_ACK) || wtx_valid;
  assign o_tx_data      = (state_q == ST_ACK) ? ACK_BYTE : wtx_data;
  assign o_p_mem_w_en   = w_en_q;
  assign o_p_mem_w_addr = w_addr_q;
  assign o_p_mem_w_data = w_data_q;
  assign o_d_mem_addr   = dmem_addr_q;
  assign o_reg_addr     = reg_addr_q;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: random memories/PC and random load words against a byte-stream model.
module tb_debug_unit;

  localparam int NR = 32;
  localparam int ND = 32;
  localparam int N_DUMP_WORDS = 1 + NR + ND;
  localparam int N_DUMP_BYTES = 4 * N_DUMP_WORDS;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] if_pc;
  logic        if_halt;
  logic [31:0] reg_data;
  logic [31:0] d_mem_data;
  logic        dbg;
  logic        clk_en;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] d_mem_addr;
  logic [4:0]  reg_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] regs_m [NR];
  logic [31:0] dmem_m [ND];
  logic [7:0]  tx_q [$];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  int          clk_en_cnt;
  bit          bp_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [7:0]  stall_data;

  always #5 clk = ~clk;

  debug_unit dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready),
    .i_if_pc        (if_pc),
    .i_if_halt      (if_halt),
    .i_reg_data     (reg_data),
    .i_d_mem_data   (d_mem_data),
    .o_debug        (dbg),
    .o_clk_en       (clk_en),
    .o_p_mem_w_en   (w_en),
    .o_p_mem_w_addr (w_addr),
    .o_p_mem_w_data (w_data),
    .o_d_mem_addr   (d_mem_addr),
    .o_reg_addr     (reg_addr)
  );

  // Register file and data memory with one cycle of read latency.
  always @(posedge clk) begin
    reg_data   <= regs_m[reg_addr];
    d_mem_data <= dmem_m[d_mem_addr[6:2]];
  end

  always @(posedge clk) begin
    #1;
    tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Observer: records transfers and strobes, and checks byte hold under backpressure.
  always @(negedge clk) begin
    if (stall_prev && !rst) begin
      n_checks++;
      if (!(tx_valid === 1'b1 && tx_data === stall_data)) begin
        n_fail++;
        $display("FAIL tx_stall_hold: valid=%b data=%02h, required valid=1 data=%02h", tx_valid, tx_data, stall_data);
      end
    end
    stall_prev = tx_valid && !tx_ready && !rst;
    stall_data = tx_data;
    if (tx_valid && tx_ready && !rst) tx_q.push_back(tx_data);
    if (w_en) begin
      wa_q.push_back(w_addr);
      wd_q.push_back(w_data);
    end
    if (clk_en) clk_en_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(gap);
  endtask

  task automatic clear_obs();
    tx_q.delete();
    wa_q.delete();
    wd_q.delete();
    clk_en_cnt = 0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c = 0;
    while (tx_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
  endtask

  task automatic randomize_state();
    if_pc = $urandom;
    for (int i = 0; i < NR; i++) regs_m[i] = $urandom;
    for (int i = 0; i < ND; i++) dmem_m[i] = $urandom;
  endtask

  function automatic logic [31:0] exp_word(input int k);
    if (k == 0) return if_pc;
    if (k <= NR) return regs_m[k-1];
    return dmem_m[k-1-NR];
  endfunction

  // Drives a load command for the given words; count byte 0 encodes 256 words.
  task automatic drive_load(input logic [31:0] words [$], input int max_gap);
    logic [31:0] w;
    send_byte(8'h4C, $urandom_range(0, max_gap));
    send_byte(8'(words.size()), $urandom_range(0, max_gap));
    foreach (words[k]) begin
      w = words[k];
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], $urandom_range(0, max_gap));
    end
  endtask

  // Waits for a full dump and reports how many words differ from the model.
  task automatic collect_dump(output int nbytes, output int bad, output string first_bad);
    logic [31:0] got;
    logic [31:0] exp;
    wait_tx(N_DUMP_BYTES, 8000);
    tick(4);
    nbytes    = tx_q.size();
    bad       = 0;
    first_bad = "none";
    for (int k = 0; k < N_DUMP_WORDS; k++) begin
      exp = exp_word(k);
      got = 32'hxxxxxxxx;
      if (tx_q.size() >= 4*k + 4) got = {tx_q[4*k], tx_q[4*k+1], tx_q[4*k+2], tx_q[4*k+3]};
      if (got !== exp) begin
        if (bad == 0) first_bad = $sformatf("word %0d got %08h want %08h", k, got, exp);
        bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_checks++;
    if ({dbg, clk_en, tx_valid, w_en} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl: debug/clk_en/tx_valid/w_en=%b, required 1000", {dbg, clk_en, tx_valid, w_en});
    end
    n_checks++;
    if ({tx_data, w_addr, w_data, d_mem_addr, reg_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: tx=%02h waddr=%08h wdata=%08h daddr=%08h raddr=%0d, required all 0",
               tx_data, w_addr, w_data, d_mem_addr, reg_addr);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_load();
    logic [31:0] words [$];
    for (int pass = 0; pass < 3; pass++) begin
      words.delete();
      if (pass == 0) words = '{32'h00000001, 32'h200000FF};
      else if (pass == 1) repeat ($urandom_range(1, 6)) words.push_back($urandom);
      else repeat (256) words.push_back($urandom);
      clear_obs();
      drive_load(words, (pass == 2) ? 0 : 3);
      wait_tx(1, 200);
      tick(3);
      n_checks++;
      if (wa_q.size() !== words.size()) begin
        n_fail++;
        $display("FAIL load%0d_count: %0d strobes, required %0d", pass, wa_q.size(), words.size());
      end else begin
        foreach (words[k]) begin
          n_checks++;
          if (wa_q[k] !== 32'(4*k) || wd_q[k] !== words[k]) begin
            n_fail++;
            $display("FAIL load%0d_word%0d: %08h@%08h, required %08h@%08h", pass, k, wd_q[k], wa_q[k], words[k], 4*k);
          end
        end
      end
      n_checks++;
      if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
        n_fail++;
        $display("FAIL load%0d_ack: %0d bytes first=%02h, required 1 byte 4b", pass, tx_q.size(),
                 (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
      end
    end
  endtask

  task automatic test_unknown();
    clear_obs();
    send_byte(8'h7A, 2);
    send_byte(8'h42, 2);
    tick(20);
    n_checks++;
    if (tx_q.size() !== 0 || wa_q.size() !== 0 || clk_en_cnt !== 0 || dbg !== 1'b1) begin
      n_fail++;
      $display("FAIL unknown_cmd: tx=%0d strobes=%0d clk_en=%0d debug=%b, required 0 0 0 1",
               tx_q.size(), wa_q.size(), clk_en_cnt, dbg);
    end
  endtask

  task automatic test_step(input bit backpressure);
    int nb, bad;
    string fb;
    randomize_state();
    bp_en = backpressure;
    clear_obs();
    send_byte(8'h53, 0);
    collect_dump(nb, bad, fb);
    bp_en = 1'b0;
    n_checks++;
    if (nb !== N_DUMP_BYTES) begin
      n_fail++;
      $display("FAIL step_bytes(bp=%0d): %0d bytes, required %0d", backpressure, nb, N_DUMP_BYTES);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL step_dump(bp=%0d): %0d bad words, first %s", backpressure, bad, fb);
    end
    n_checks++;
    if (clk_en_cnt !== 1 || dbg !== 1'b1) begin
      n_fail++;
      $display("FAIL step_clk_en(bp=%0d): %0d cycles debug=%b, required 1 cycle debug=1", backpressure, clk_en_cnt, dbg);
    end
  endtask

  task automatic test_run_halt();
    int nb, bad, low;
    string fb;
    randomize_state();
    clear_obs();
    if_halt = 1'b0;
    send_byte(8'h43, 0);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (clk_en !== 1'b1 || dbg !== 1'b0) low++;
      tick(1);
    end
    n_checks++;
    if (low !== 0) begin
      n_fail++;
      $display("FAIL run_clk_en: %0d of 10 run cycles without clk_en/debug low, required 0", low);
    end
    if_halt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL run_halt_cycle: clk_en=%b, required 0", clk_en);
    end
    tick(1);
    collect_dump(nb, bad, fb);
    if_halt = 1'b0;
    n_checks++;
    if (nb !== N_DUMP_BYTES || bad !== 0) begin
      n_fail++;
      $display("FAIL run_dump: %0d bytes %0d bad words (%s), required %0d bytes 0 bad", nb, bad, fb, N_DUMP_BYTES);
    end
    n_checks++;
    if (clk_en_cnt !== 10) begin
      n_fail++;
      $display("FAIL run_en_total: %0d cycles, required 10", clk_en_cnt);
    end
  endtask

  task automatic test_run_break();
    int nb, bad;
    string fb;
    randomize_state();
    clear_obs();
    send_byte(8'h43, 3);
    send_byte(8'h11, 1);
    send_byte(8'h42, 0);
    collect_dump(nb, bad, fb);
    n_checks++;
    if (nb !== N_DUMP_BYTES || bad !== 0) begin
      n_fail++;
      $display("FAIL break_dump: %0d bytes %0d bad words (%s), required %0d bytes 0 bad", nb, bad, fb, N_DUMP_BYTES);
    end
    // Run lasts from the 'C' edge to the 'B' edge: 1+3+1+1 cycles.
    n_checks++;
    if (clk_en_cnt !== 6) begin
      n_fail++;
      $display("FAIL break_en_total: %0d cycles, required 6", clk_en_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] one [$];
    clear_obs();
    send_byte(8'h4C, 2);
    send_byte(8'h02, 2);
    send_byte(8'hDE, 2);
    send_byte(8'hAD, 2);
    send_byte(8'hBE, 1);
    rst = 1'b1;
    tick(2);
    n_checks++;
    if ({dbg, clk_en, tx_valid, w_en} !== 4'b1000 || {tx_data, w_addr, w_data} !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: ctrl=%b tx=%02h waddr=%08h wdata=%08h, required 1000/0/0/0",
               {dbg, clk_en, tx_valid, w_en}, tx_data, w_addr, w_data);
    end
    rst = 1'b0;
    tick(1);
    clear_obs();
    one.push_back($urandom);
    drive_load(one, 2);
    wait_tx(1, 100);
    tick(3);
    n_checks++;
    if (wa_q.size() !== 1 || wa_q[0] !== 32'h0 || wd_q[0] !== one[0] || tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
      n_fail++;
      $display("FAIL midload_restart: strobes=%0d addr=%08h data=%08h tx=%0d, required 1 @0 %08h ack",
               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 32'hx, (wd_q.size() > 0) ? wd_q[0] : 32'hx,
               tx_q.size(), one[0]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    if_halt  = 1'b0;
    if_pc    = 32'h0;
    for (int i = 0; i < NR; i++) regs_m[i] = 32'h0;
    for (int i = 0; i < ND; i++) dmem_m[i] = 32'h0;
    tick(1);
    test_reset();
    test_load();
    test_unknown();
    test_step(1'b0);
    test_run_halt();
    test_run_break();
    test_step(1'b1);
    test_step(1'b1);
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
